// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and bus mode constants
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK half-period divider, one tick every CLK_DIV cycles while enabled
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_c,
  input  logic reset_r,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master, one full-duplex N-bit word per start request
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk_c,
  input  logic         reset_r,
  input  logic         start_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         sclk_o,
  output logic         mosi_o,
  input  logic         miso_i,
  output logic         cs_n_o
);

  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  spi_state_e   state_q, state_d;
  logic [N-1:0] tx_q, tx_d;
  logic [N-1:0] rx_q, rx_d;
  logic [N-1:0] data_q, data_d;
  logic [BW-1:0] bit_q, bit_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic cs_n_q, cs_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic div_en;
  logic tick;

  assign div_en = (state_q != IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_c  (clk_c),
    .reset_r(reset_r),
    .en_i   (div_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_d    = data_i;
          rx_d    = '0;
          bit_d   = '0;
          mosi_d  = data_i[N-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[N-2:0], miso_i};
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[N-2:0], miso_i};
          end else begin
            // Falling edge: either present the next bit or finish the frame.
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 1'b1;
              tx_d   = tx_q << 1;
              mosi_d = tx_q[N-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl (8/4 and 16/2 instances)
module tb_spi_master_ctrl;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          rises;
  } exp_t;

  logic clk_c;
  logic reset_r;
  int   cyc;
  int   checks;
  int   errors;

  logic        start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_n_a;
  logic [7:0]  data_a, data_o_a;
  logic        start_b, busy_b, done_b, sclk_b, mosi_b, miso_b, cs_n_b;
  logic [15:0] data_b, data_o_b;

  logic       loop_a;
  logic       slv_miso;
  logic [7:0] slv_sh, slv_rx;
  logic [7:0] slv_word;

  exp_t qa[$];
  exp_t qb[$];
  int   rises_a, rises_b, stab_a, stab_b, done_cnt_a;
  bit   sclk_pa, sclk_pb, cs_pa, cs_pb;
  logic mosi_pa, mosi_pb;

  spi_master_ctrl #(.N(8), .CLK_DIV(4)) dut_a (
    .clk_c(clk_c), .reset_r(reset_r), .start_i(start_a), .data_i(data_a),
    .data_o(data_o_a), .busy_o(busy_a), .done_o(done_a), .sclk_o(sclk_a),
    .mosi_o(mosi_a), .miso_i(miso_a), .cs_n_o(cs_n_a)
  );

  spi_master_ctrl #(.N(16), .CLK_DIV(2)) dut_b (
    .clk_c(clk_c), .reset_r(reset_r), .start_i(start_b), .data_i(data_b),
    .data_o(data_o_b), .busy_o(busy_b), .done_o(done_b), .sclk_o(sclk_b),
    .mosi_o(mosi_b), .miso_i(miso_b), .cs_n_o(cs_n_b)
  );

  assign miso_a = loop_a ? mosi_a : slv_miso;
  assign miso_b = mosi_b;

  initial clk_c = 1'b0;
  always #5 clk_c = ~clk_c;

  initial cyc = 0;
  always @(posedge clk_c) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural mode-0 slave: shifts out on SCLK fall, samples on SCLK rise.
  always @(negedge cs_n_a) begin
    slv_sh   = slv_word;
    slv_miso = slv_sh[7];
    slv_rx   = 8'h00;
  end
  always @(posedge sclk_a) if (!cs_n_a) slv_rx = {slv_rx[6:0], mosi_a};
  always @(negedge sclk_a) if (!cs_n_a) begin
    slv_sh   = slv_sh << 1;
    slv_miso = slv_sh[7];
  end

  always @(negedge clk_c) begin
    exp_t e;
    if (!cs_n_a && cs_pa) rises_a = 0;
    if (sclk_a && !sclk_pa) begin
      rises_a++;
      if (mosi_a !== mosi_pa) stab_a++;
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_a: got done with data %0h, required no done", data_o_a);
      end else begin
        e = qa.pop_front();
        chk("data_a", 32'(data_o_a), e.data);
        chk("done_cycle_a", cyc, e.cyc);
        chk("rises_a", rises_a, e.rises);
        chk("busy_in_done_a", 32'(busy_a), 0);
        chk("cs_n_in_done_a", 32'(cs_n_a), 1);
      end
    end
    sclk_pa = sclk_a;
    cs_pa   = cs_n_a;
    mosi_pa = mosi_a;
  end

  always @(negedge clk_c) begin
    exp_t e;
    if (!cs_n_b && cs_pb) rises_b = 0;
    if (sclk_b && !sclk_pb) begin
      rises_b++;
      if (mosi_b !== mosi_pb) stab_b++;
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_b: got done with data %0h, required no done", data_o_b);
      end else begin
        e = qb.pop_front();
        chk("data_b", 32'(data_o_b), e.data);
        chk("done_cycle_b", cyc, e.cyc);
        chk("rises_b", rises_b, e.rises);
      end
    end
    sclk_pb = sclk_b;
    cs_pb   = cs_n_b;
    mosi_pb = mosi_b;
  end

  task automatic start_xfer_a(input logic [7:0] d, input logic [7:0] expd, input bit push);
    @(negedge clk_c);
    start_a = 1'b1;
    data_a  = d;
    if (push) qa.push_back('{32'(expd), cyc + 69, 8});
    @(negedge clk_c);
    start_a = 1'b0;
    chk("cs_n_fall_a", 32'(cs_n_a), 0);
    chk("busy_set_a", 32'(busy_a), 1);
    chk("mosi_first_a", 32'(mosi_a), 32'(d[7]));
  endtask

  task automatic drain_a();
    for (int i = 0; i < 300 && qa.size() != 0; i++) @(negedge clk_c);
    chk("drain_a", qa.size(), 0);
    qa.delete();
  endtask

  task automatic drain_b();
    for (int i = 0; i < 300 && qb.size() != 0; i++) @(negedge clk_c);
    chk("drain_b", qb.size(), 0);
    qb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, dc;
    checks = 0; errors = 0;
    rises_a = 0; rises_b = 0; stab_a = 0; stab_b = 0; done_cnt_a = 0;
    sclk_pa = 0; sclk_pb = 0; cs_pa = 1; cs_pb = 1;
    start_a = 0; data_a = 0; start_b = 0; data_b = 0;
    loop_a = 1; slv_word = 8'h3C; slv_miso = 0; slv_sh = 0; slv_rx = 0;
    reset_r = 1'b1;
    repeat (3) @(negedge clk_c);
    chk("rst_cs_n", 32'(cs_n_a), 1);
    chk("rst_sclk", 32'(sclk_a), 0);
    chk("rst_mosi", 32'(mosi_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_data", 32'(data_o_a), 0);
    reset_r = 1'b0;
    repeat (2) @(negedge clk_c);

    // Loopback A5
    start_xfer_a(8'hA5, 8'hA5, 1);
    drain_a();

    // Slave returns 3C while master sends C3
    loop_a = 0;
    start_xfer_a(8'hC3, 8'h3C, 1);
    drain_a();
    chk("slave_captured", 32'(slv_rx), 32'h0000_00C3);
    loop_a = 1;
    repeat (2) @(negedge clk_c);

    // Start pulsed mid-transfer is ignored
    start_xfer_a(8'h12, 8'h12, 1);
    repeat (19) @(negedge clk_c);
    start_a = 1'b1;
    data_a  = 8'hFF;
    @(negedge clk_c);
    start_a = 1'b0;
    drain_a();

    // Back-to-back with start held high
    @(negedge clk_c);
    c0 = cyc;
    start_a = 1'b1;
    data_a  = 8'h01;
    qa.push_back('{32'h01, c0 + 69, 8});
    @(negedge clk_c);
    data_a = 8'h80;
    repeat (68) @(negedge clk_c);
    qa.push_back('{32'h80, c0 + 138, 8});
    chk("b2b_gap_cs_n_high", 32'(cs_n_a), 1);
    @(negedge clk_c);
    chk("b2b_cs_n_refall", 32'(cs_n_a), 0);
    chk("b2b_busy", 32'(busy_a), 1);
    start_a = 1'b0;
    drain_a();

    // Asynchronous reset at cycle 30
    start_xfer_a(8'h77, 8'h00, 0);
    repeat (29) @(negedge clk_c);
    dc = done_cnt_a;
    reset_r = 1'b1;
    #1;
    chk("midrst_cs_n", 32'(cs_n_a), 1);
    chk("midrst_sclk", 32'(sclk_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_data", 32'(data_o_a), 0);
    repeat (3) @(negedge clk_c);
    reset_r = 1'b0;
    repeat (75) @(negedge clk_c);
    chk("no_done_after_reset", done_cnt_a - dc, 0);
    start_xfer_a(8'h5A, 8'h5A, 1);
    drain_a();

    // N=16, CLK_DIV=2 loopback
    @(negedge clk_c);
    start_b = 1'b1;
    data_b  = 16'hBEEF;
    qb.push_back('{32'h0000_BEEF, cyc + 67, 16});
    @(negedge clk_c);
    start_b = 1'b0;
    chk("cs_n_fall_b", 32'(cs_n_b), 0);
    drain_b();

    repeat (3) @(negedge clk_c);
    chk("mosi_stable_a", stab_a, 0);
    chk("mosi_stable_b", stab_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master (mode 0: CPOL=0, CPHA=0, MSB first), one N-bit full-duplex transfer per start request.
- Drives sclk_o, mosi_o and cs_n_o toward the slave side of the bus and samples miso_i.
- Presents the received word with a one-cycle done pulse.
- Sits between a local controller (start/data handshake) and the SPI pins. It is the initiating end for the team's SPI slave shift path.

Parameters:
- N, 8, word length in bits (N >= 2).
- CLK_DIV, 4, clk_c cycles per SCLK half-period (CLK_DIV >= 2).

Ports:
- clk_c  input  1  system clock
- reset_r  input  1  reset, asynchronous, active-high
- start_i  input  1  request transfer; sampled only while busy_o==0
- data_i  input  N  word to transmit; captured in the accept cycle
- data_o  output  N  last received word; updated with done_o
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse, transfer complete
- sclk_o  output  1  SPI clock, idle low
- mosi_o  output  1  serial data to slave
- miso_i  input  1  serial data from slave
- cs_n_o  output  1  chip select, active low

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, data_o=0.
  - FSM goes to IDLE; divider and bit counters are cleared. No partial word is reported.
- All outputs are registered.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - When start_i=1 (cycle 0): load tx shift register from data_i, clear the rx register and divider.
  - Next state SETUP. At cycle 1, cs_n_o=0, busy_o=1 and mosi_o=data_i[N-1].
- Divider:
  - Counts 0..CLK_DIV-1 in SETUP, XFER and HOLD.
  - Generates tick when the count reaches CLK_DIV-1, then wraps to 0.
- SETUP: on tick go to XFER and drive sclk_o=1 (first rising edge). miso_i is sampled into rx[0], rx shifts left.
- XFER: sclk_o toggles on every tick.
  - Rising edge: rx <= {rx[N-2:0], miso_i}.
  - Falling edge with bit_cnt < N-1: bit_cnt++, tx shifts left, mosi_o <= next bit.
  - Falling edge with bit_cnt == N-1: go to HOLD; sclk_o stays 0.
- HOLD: on tick, cs_n_o=1, busy_o=0, done_o=1 for one cycle, data_o <= rx; go to IDLE.
- Timing (first rising edge at cycle 1+CLK_DIV):
  - Exactly N rising and N falling SCLK edges per transfer.
  - done_o/cs_n_o release at cycle 1+(2N+1)*CLK_DIV. Defaults (N=8, CLK_DIV=4): cycle 69.
- Ordering: mosi_o changes only on falling edges or at SETUP entry, i.e. it is stable across each rising edge.
- start_i while busy_o=1 is ignored (no queuing).
- start_i in the done_o cycle (busy_o=0) is accepted; cs_n_o is high for at least that one cycle.
- data_o holds its value until the next done_o.
- bit_cnt width is $clog2(N). Divider width is $clog2(CLK_DIV).

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] spi_state_e {IDLE, SETUP, XFER, HOLD};
  - localparam CPOL=0, CPHA=0 constants shared with the slave side.
- Sub-module spi_clk_div: parameter CLK_DIV; inputs clk_c, reset_r, en_i; output tick_o.
  - Counter clears when en_i=0.
  - Instantiated once; the FSM uses tick_o.

Test Plan:
- Loopback (miso_i=mosi_o), start_i with data_i=8'hA5 at cycle 0 -> cs_n_o falls at cycle 1; 8 sclk rising edges; done_o=1 and data_o=8'hA5 at cycle 69; busy_o=0 same cycle.
- Behavioural mode-0 slave returning 8'h3C, master sends 8'hC3 -> slave captures 8'hC3 and data_o=8'h3C. mosi_o is never changing in the cycle sclk_o rises.
- start_i pulsed again at cycle 20 with data_i=8'hFF during an 8'h12 transfer -> ignored; data_o=8'h12 (loopback); exactly 8 rising edges.
- reset_r asserted at cycle 30 mid-transfer -> same cycle cs_n_o=1, sclk_o=0, busy_o=0, data_o=0; no done_o. New start after release completes normally at 69 cycles.
- Back-to-back: start_i held high continuously with 8'h01 then 8'h80 -> second transfer is accepted in the done_o cycle. cs_n_o is high exactly one cycle between frames; data_o=8'h01 then 8'h80.
- CLK_DIV=2, N=16, loopback 16'hBEEF -> done_o at cycle 1+33*2=67, data_o=16'hBEEF, 16 rising edges.
